// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: SPI slave command sequencer. Synchronizes the slave's byte-done
// toggle and chip select into clk, parses command/address/data bytes and drives
// a single-port memory request/acknowledge interface.
module spi_cmd_ctrl #(
    parameter int unsigned ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              spi_finished,
    input  logic [7:0]        spi_in_byte,
    output logic [7:0]        spi_out_byte,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam int unsigned SPI_ADDR_W = 24;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h05;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR2,
        S_ADDR1,
        S_ADDR0,
        S_WR_DATA,
        S_WR_MEM,
        S_RD_MEM,
        S_RD_DATA,
        S_STAT,
        S_DISCARD
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_cs_meta;
    logic r_cs_sync;
    logic r_fin_meta;
    logic r_fin_sync;
    logic r_fin_prev;
    logic r_byte_valid;
    logic [7:0] r_byte;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [7:0]        r_out_byte;
    logic              r_err;
    logic              r_ovr;
    logic              r_busy;
    logic              r_is_write;
    logic [15:0]       r_addr_hi;

    logic              w_req_nxt;
    logic              w_we_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_wdata_nxt;
    logic [7:0]        w_out_nxt;
    logic              w_err_nxt;
    logic              w_ovr_nxt;
    logic              w_is_write_nxt;
    logic [15:0]       w_addr_hi_nxt;

    logic                  w_bv;
    logic                  w_ack;
    logic [ADDR_W-1:0]     w_addr_inc;
    logic [SPI_ADDR_W-1:0] w_addr_full;

    // Two-flop synchronizers plus a registered edge detect on the byte-done toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs_meta    <= 1'b1;
            r_cs_sync    <= 1'b1;
            r_fin_meta   <= 1'b0;
            r_fin_sync   <= 1'b0;
            r_fin_prev   <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte       <= 8'h00;
        end else begin
            r_cs_meta    <= cs;
            r_cs_sync    <= r_cs_meta;
            r_fin_meta   <= spi_finished;
            r_fin_sync   <= r_fin_meta;
            r_fin_prev   <= r_fin_sync;
            r_byte_valid <= r_fin_sync ^ r_fin_prev;
            if (r_fin_sync ^ r_fin_prev) begin
                r_byte <= spi_in_byte;
            end
        end
    end

    // Bytes seen while deselected (including the cs-rise cycle) are dropped
    assign w_bv        = r_byte_valid & ~r_cs_sync;
    assign w_ack       = mem_ack & r_mem_req;
    assign w_addr_inc  = r_mem_addr + ADDR_W'(1);
    assign w_addr_full = {r_addr_hi, r_byte};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_mem_req;
        w_we_nxt       = r_mem_we;
        w_addr_nxt     = r_mem_addr;
        w_wdata_nxt    = r_mem_wdata;
        w_out_nxt      = r_out_byte;
        w_err_nxt      = r_err;
        w_ovr_nxt      = r_ovr;
        w_is_write_nxt = r_is_write;
        w_addr_hi_nxt  = r_addr_hi;

        if (r_cs_sync) begin
            // Deselect: finish an outstanding request before returning to idle
            if (r_mem_req) begin
                if (w_ack) begin
                    w_req_nxt   = 1'b0;
                    w_addr_nxt  = w_addr_inc;
                    w_state_nxt = S_IDLE;
                    if (!r_mem_we) begin
                        w_out_nxt = mem_rdata;
                    end
                end
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_bv) begin
                        case (r_byte)
                            CMD_WRITE: begin
                                w_is_write_nxt = 1'b1;
                                w_state_nxt    = S_ADDR2;
                            end
                            CMD_READ: begin
                                w_is_write_nxt = 1'b0;
                                w_state_nxt    = S_ADDR2;
                            end
                            CMD_STATUS: begin
                                w_out_nxt   = {5'b0, r_ovr, r_err, 1'b1};
                                w_ovr_nxt   = 1'b0;
                                w_err_nxt   = 1'b0;
                                w_state_nxt = S_STAT;
                            end
                            default: begin
                                w_err_nxt   = 1'b1;
                                w_state_nxt = S_DISCARD;
                            end
                        endcase
                    end
                end
                S_ADDR2: begin
                    if (w_bv) begin
                        w_addr_hi_nxt = {r_byte, r_addr_hi[7:0]};
                        w_state_nxt   = S_ADDR1;
                    end
                end
                S_ADDR1: begin
                    if (w_bv) begin
                        w_addr_hi_nxt = {r_addr_hi[15:8], r_byte};
                        w_state_nxt   = S_ADDR0;
                    end
                end
                S_ADDR0: begin
                    if (w_bv) begin
                        w_addr_nxt = w_addr_full[ADDR_W-1:0];
                        if (r_is_write) begin
                            w_state_nxt = S_WR_DATA;
                        end else begin
                            w_req_nxt   = 1'b1;
                            w_we_nxt    = 1'b0;
                            w_state_nxt = S_RD_MEM;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_bv) begin
                        w_wdata_nxt = r_byte;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b1;
                        w_state_nxt = S_WR_MEM;
                    end
                end
                S_WR_MEM: begin
                    if (w_bv) begin
                        w_ovr_nxt = 1'b1;
                    end
                    if (w_ack) begin
                        w_req_nxt   = 1'b0;
                        w_addr_nxt  = w_addr_inc;
                        w_state_nxt = S_WR_DATA;
                    end
                end
                S_RD_MEM: begin
                    if (w_bv) begin
                        w_ovr_nxt = 1'b1;
                    end
                    if (w_ack) begin
                        w_req_nxt   = 1'b0;
                        w_out_nxt   = mem_rdata;
                        w_addr_nxt  = w_addr_inc;
                        w_state_nxt = S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (w_bv) begin
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_state_nxt = S_RD_MEM;
                    end
                end
                S_STAT, S_DISCARD: begin
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_out_byte  <= 8'h00;
            r_err       <= 1'b0;
            r_ovr       <= 1'b0;
            r_busy      <= 1'b0;
            r_is_write  <= 1'b0;
            r_addr_hi   <= 16'h0000;
        end else begin
            r_mem_req   <= w_req_nxt;
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_addr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_out_byte  <= w_out_nxt;
            r_err       <= w_err_nxt;
            r_ovr       <= w_ovr_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_is_write  <= w_is_write_nxt;
            r_addr_hi   <= w_addr_hi_nxt;
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign spi_out_byte = r_out_byte;
    assign err          = r_err;
    assign busy         = r_busy;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: byte-level SPI slave stand-in, a memory responder
// that checks each request against a queue of expected operations, a table of
// whole transactions, and hand-written sequences for stall/deselect/reset cases.
module tb_spi_cmd_ctrl;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned GAP    = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cs;
    logic              spi_finished;
    logic [7:0]        spi_in_byte;
    logic [7:0]        spi_out_byte;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack = 1'b0;
    logic [7:0]        mem_rdata = 8'h00;
    logic              busy;
    logic              err;

    int total = 0;
    int bad   = 0;
    int mem_lat = 2;
    int mem_cnt = 0;

    logic [7:0] mem_model [0:255];

    typedef struct packed {
        logic        we;
        logic [23:0] addr;
        logic [7:0]  data;
    } op_t;

    op_t exp_q[$];
    op_t mem_e;

    typedef struct {
        logic [47:0] bytes;
        int          n;
        logic [5:0]  chk;
        logic [47:0] outs;
        logic        exp_err;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    spi_cmd_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cs           (cs),
        .spi_finished (spi_finished),
        .spi_in_byte  (spi_in_byte),
        .spi_out_byte (spi_out_byte),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] getb(input logic [47:0] v, input int i);
        return v[47-8*i -: 8];
    endfunction

    // Memory responder: acks after mem_lat cycles of request, checks each op against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0;
                mem_cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                mem_cnt++;
                if (mem_cnt >= mem_lat) begin
                    mem_cnt = 0;
                    mem_ack = 1'b1;
                    if (!mem_we) mem_rdata = mem_model[mem_addr[7:0]];
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb_unexpected: got req we=%b addr=%h want none", mem_we, mem_addr);
                    end else begin
                        mem_e = exp_q.pop_front();
                        check("sb_we", 32'(mem_we), 32'(mem_e.we));
                        check("sb_addr", 32'(mem_addr), 32'(mem_e.addr));
                        if (mem_e.we) check("sb_wdata", 32'(mem_wdata), 32'(mem_e.data));
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        spi_in_byte  = b;
        spi_finished = ~spi_finished;
        repeat (gap) @(negedge clk);
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Expected memory operations implied by one transaction's byte stream
    task automatic push_expect(input vec_t v);
        logic [7:0]  c;
        logic [23:0] a;
        c = getb(v.bytes, 0);
        a = {getb(v.bytes, 1), getb(v.bytes, 2), getb(v.bytes, 3)};
        if (c == 8'h02) begin
            for (int k = 4; k < v.n; k++)
                exp_q.push_back('{1'b1, a + 24'(k - 4), getb(v.bytes, k)});
        end else if (c == 8'h03 && v.n >= 4) begin
            for (int k = 0; k <= v.n - 4; k++)
                exp_q.push_back('{1'b0, a + 24'(k), 8'h00});
        end
    endtask

    initial begin
        int w;
        rst_n        = 1'b0;
        cs           = 1'b1;
        spi_finished = 1'b0;
        spi_in_byte  = 8'h00;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'h5A;
        mem_model[8'h10] = 8'h5C;
        mem_model[8'h11] = 8'hC3;
        mem_model[8'h12] = 8'hA5;

        // bytes, n, chk (bit i = check out after byte i), outs, err after deselect
        vecs[0] = '{48'h02_12_34_56_AA_BB, 6, 6'b100000, 48'h00_00_00_00_00_00, 1'b0};
        vecs[1] = '{48'h02_FF_FF_FF_11_22, 6, 6'b000000, 48'h00_00_00_00_00_00, 1'b0};
        vecs[2] = '{48'h02_00_01_00_00_00, 4, 6'b000000, 48'h00_00_00_00_00_00, 1'b0};
        vecs[3] = '{48'h03_00_00_10_00_00, 6, 6'b111000, 48'h00_00_00_5C_C3_A5, 1'b0};
        vecs[4] = '{48'h7E_02_00_00_00_00, 3, 6'b000010, 48'h00_A5_00_00_00_00, 1'b1};
        vecs[5] = '{48'h05_00_00_00_00_00, 1, 6'b000001, 48'h03_00_00_00_00_00, 1'b0};
        vecs[6] = '{48'h05_00_00_00_00_00, 1, 6'b000001, 48'h01_00_00_00_00_00, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_out_byte", spi_out_byte, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);

        for (int t = 0; t < NV; t++) begin
            push_expect(vecs[t]);
            cs_low();
            for (int i = 0; i < vecs[t].n; i++) begin
                send_byte(getb(vecs[t].bytes, i), GAP);
                if (i == 0) check($sformatf("v%0d_busy", t), busy, 1);
                if (vecs[t].chk[i])
                    check($sformatf("v%0d_out%0d", t, i), spi_out_byte, getb(vecs[t].outs, i));
            end
            cs_high();
            check($sformatf("v%0d_idle", t), busy, 0);
            check($sformatf("v%0d_err", t), err, vecs[t].exp_err);
            check($sformatf("v%0d_sb_drained", t), exp_q.size(), 0);
        end

        // Overrun: second data byte arrives while the first write is stalled
        exp_q.push_back('{1'b1, 24'h000040, 8'hAA});
        mem_lat = 20;
        cs_low();
        send_byte(8'h02, GAP);
        send_byte(8'h00, GAP);
        send_byte(8'h00, GAP);
        send_byte(8'h40, GAP);
        send_byte(8'hAA, 6);
        send_byte(8'hBB, 40);
        cs_high();
        mem_lat = 2;
        check("ovr_one_write", exp_q.size(), 0);
        cs_low();
        send_byte(8'h05, GAP);
        check("ovr_status", spi_out_byte, 8'h05);
        cs_high();
        check("ovr_err_clear", err, 0);

        // Deselect while a read request is outstanding
        exp_q.push_back('{1'b0, 24'h000010, 8'h00});
        mem_lat = 20;
        cs_low();
        send_byte(8'h03, GAP);
        send_byte(8'h00, GAP);
        send_byte(8'h00, GAP);
        send_byte(8'h10, 4);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("cs_hold_req", mem_req, 1);
        check("cs_hold_busy", busy, 1);
        w = 0;
        while (mem_req && w < 40) begin
            @(negedge clk);
            w++;
        end
        check("cs_req_drop", mem_req, 0);
        repeat (2) @(negedge clk);
        check("cs_idle", busy, 0);
        check("cs_read_out", spi_out_byte, 8'h5C);
        check("cs_sb_drained", exp_q.size(), 0);
        mem_lat = 2;

        // Asynchronous reset in the middle of the address phase
        cs_low();
        send_byte(8'h02, GAP);
        send_byte(8'h12, GAP);
        check("prerst_busy", busy, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_mem_req", mem_req, 0);
        check("arst_mem_we", mem_we, 0);
        check("arst_mem_addr", mem_addr, 0);
        check("arst_mem_wdata", mem_wdata, 0);
        check("arst_out_byte", spi_out_byte, 0);
        check("arst_err", err, 0);
        cs = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_idle", busy, 0);

        check("sb_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
# spi_cmd_ctrl

Command sequencer for the cartridge SPI slave port. It runs in the system clock domain, synchronizes the slave's per-byte `finished` toggle and chip select, parses the master's byte stream (command, 24-bit address, data), and drives a single-port memory request/acknowledge interface. It also loads the slave's `out_byte` with read data or status so the master can clock it out on the following byte.

## Interface
- `ADDR_W`, 24: memory address width; the 24-bit SPI address is truncated to its low `ADDR_W` bits (1..24).
- `clk` in 1: system clock; the SPI-side signals below are asynchronous to it.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cs` in 1: SPI chip select, active-low, asynchronous; 2-flop synchronized internally.
- `spi_finished` in 1: byte-done toggle from the slave; 2-flop synchronized, then edge detected.
- `spi_in_byte` in 8: last byte received by the slave; sampled only on a detected edge.
- `spi_out_byte` out 8: byte the slave shifts out next.
- `mem_req` out 1: memory request, held high until ack.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr` out ADDR_W: request address.
- `mem_wdata` out 8: write data.
- `mem_ack` in 1: one-cycle completion pulse.
- `mem_rdata` in 8: read data, valid in the `mem_ack` cycle.
- `busy` out 1: FSM not in IDLE.
- `err` out 1: sticky error flag, mirrors the status register bit 1.

## Operation
- `byte_valid`: single-cycle pulse when the synchronized `spi_finished` differs from its previous registered value. Bytes arriving while `cs_sync` is high are ignored.
- Commands (first byte after `cs` falls):
  - 0x02 WRITE
  - 0x03 READ
  - 0x05 STATUS
  - any other value: sets `err`, FSM goes to DISCARD.
- States: IDLE, ADDR2, ADDR1, ADDR0, WR_DATA, WR_MEM, RD_MEM, RD_DATA, STAT, DISCARD.
- IDLE:
  - byte_valid with 0x02 or 0x03 → ADDR2.
  - byte_valid with 0x05 → STAT. `spi_out_byte` = {5'b0, ovr, err, busy=1}, then `ovr` and `err` clear.
- ADDR2/ADDR1/ADDR0: capture address bits [23:16], [15:8], [7:0] on successive byte_valid pulses. After ADDR0: WRITE → WR_DATA; READ → RD_MEM.
- WR_DATA: byte_valid → `mem_wdata` = byte, `mem_req`=1, `mem_we`=1 → WR_MEM.
- WR_MEM: on `mem_ack`, drop `mem_req`, addr += 1 → WR_DATA.
- RD_MEM: `mem_req`=1, `mem_we`=0. On `mem_ack`, `spi_out_byte` = `mem_rdata`, addr += 1 → RD_DATA.
- RD_DATA: byte_valid (dummy byte, value ignored) → RD_MEM, which prefetches the next byte.
- STAT and DISCARD: consume bytes with no action; `spi_out_byte` holds its value.
- Address arithmetic: increments modulo 2^ADDR_W (all-ones wraps to 0). The address register persists across transactions until overwritten.
- Overrun: byte_valid in WR_MEM or RD_MEM sets sticky `ovr` and drops the byte; the state is unchanged.
- `cs_sync` high in any state:
  - if `mem_req` is high, keep it (and addr/data/we) until `mem_ack`, then → IDLE;
  - otherwise → IDLE next cycle.
  - A read ack completing this way still updates `spi_out_byte`.
- Simultaneous `cs_sync` rise and byte_valid: the byte is dropped and the cs rule applies.
- `spi_out_byte` is never changed in IDLE.

## Timing
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `spi_out_byte`=0x00, `busy`=0, `err`=0, `ovr`=0, state IDLE, synchronizer flops = 1 for cs and 0 for finished.
- Reset mid-transfer aborts immediately: `mem_req` drops with no ack wait.
- Toggle to byte_valid latency: 3 clk edges (2 sync + edge register).
- byte_valid to `mem_req` high: 1 cycle.
- `mem_req` stays high through the cycle in which `mem_ack` is sampled and is low the following cycle. The minimum write cycle is 2 clk.
- `mem_ack` while `mem_req` is low is ignored.
- Read: `spi_out_byte` updates 1 cycle after `mem_ack`.
- Master requirement: the inter-byte gap (last SCK of a byte to the first SCK of the next) must be ≥ 4 clk plus memory latency plus 1 clk, so `out_byte` is stable before the slave samples its MSB.
- `busy` is registered from the state.

## Test plan
- WRITE 0x02,0x12,0x34,0x56,0xAA,0xBB → writes 0xAA @0x123456 then 0xBB @0x123457; `mem_we`=1; `busy` drops after `cs` rises.
- READ 0x03,0x00,0x00,0x10, then dummy bytes, with memory returning 0x5C@0x10 and 0xC3@0x11 → `spi_out_byte` = 0x5C, then 0xC3; read requests issued at 0x10, 0x11, 0x12.
- WRITE at 0xFFFFFF with two data bytes → second write goes to address 0x000000.
- Invalid command 0x7E → `err`=1, no `mem_req`. Next STATUS → `spi_out_byte`=0x03, then `err`=0; a second STATUS → 0x01.
- Write with `mem_ack` stalled 20 cycles while the next byte arrives → `ovr` set, that byte is not written, and STATUS reads 0x05.
- `cs` raised while a read request is pending → `mem_req` held until ack, then IDLE. Separately, asserting `rst_n`=0 mid-address drops all outputs to reset values asynchronously.
